// File: rtl/alu_pkg.sv
// Shared encodings for the ALU second-operand stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: operand select codes, skid-buffer FSM state encoding and
// is_legal_sel(), which reports whether a select code names a real operand.
package alu_pkg;

    localparam logic [2:0] SEL_B       = 3'b000;
    localparam logic [2:0] SEL_INC     = 3'b001;
    localparam logic [2:0] SEL_SIMM    = 3'b010;
    localparam logic [2:0] SEL_SIMM_SH = 3'b011;
    localparam logic [2:0] SEL_ZIMM    = 3'b100;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    // Codes 101..111 are reserved.
    function automatic logic is_legal_sel(input logic [2:0] sel);
        return (sel <= SEL_ZIMM);
    endfunction

endpackage

// File: rtl/alu_in2_format.sv
// Combinational formation of ALU operand 2 from B, the increment constant or an immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the operand is captured.
//
// Ports: sel (operand select), b_in (B register), imm_in (raw immediate),
//        operand (formed value), illegal (sel is a reserved code, operand forced to 0).
// Optional: ALU_IN2_FWD_EN adds fwd_valid/fwd_data, which replace b_in for SEL_B.
module alu_in2_format
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_INC = 1,
    parameter int SHAMT     = 2
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] b_in,
    input  logic [IMM_W-1:0] imm_in,
`ifdef ALU_IN2_FWD_EN
    input  logic             fwd_valid,
    input  logic [WIDTH-1:0] fwd_data,
`endif
    output logic [WIDTH-1:0] operand,
    output logic             illegal
);

    logic signed [IMM_W-1:0] imm_s;
    logic [WIDTH-1:0]        simm;
    logic [WIDTH-1:0]        zimm;
    logic [WIDTH-1:0]        b_sel;

    // A size cast of a signed value sign-extends; this also stays legal
    // when IMM_W == WIDTH, where an explicit zero-width replication would not.
    assign imm_s = imm_in;
    assign simm  = WIDTH'(imm_s);
    assign zimm  = WIDTH'(imm_in);

`ifdef ALU_IN2_FWD_EN
    assign b_sel = fwd_valid ? fwd_data : b_in;
`else
    assign b_sel = b_in;
`endif

    always_comb begin
        operand = '0;
        illegal = !is_legal_sel(sel);
        case (sel)
            SEL_B:       operand = b_sel;
            SEL_INC:     operand = WIDTH'(CONST_INC);
            SEL_SIMM:    operand = simm;
            // Shift happens at full width, so high bits fall off and zeros fill in.
            SEL_SIMM_SH: operand = simm << SHAMT;
            SEL_ZIMM:    operand = zimm;
            default:     operand = '0;
        endcase
    end

endmodule

// File: rtl/alu_in2_stage.sv
// Registered ALU operand-2 select with a 2-entry (output + skid) buffer.
// Latency: 1 cycle from accept to out_valid/out_data.
// Backpressure: in_ready drops only once both entries hold data (SKID); full throughput otherwise.
//
// Ports: clk, rst_n (async active-low); b_in, imm_in, sel_in, in_valid -> in_ready request side;
//        out_data, out_valid <- out_ready ALU side; err_clr clears the sticky err_illegal_sel.
// Optional: ALU_IN2_FWD_EN adds fwd_valid/fwd_data (forwarded B for select 000).
module alu_in2_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_INC = 1,
    parameter int SHAMT     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] b_in,
    input  logic [IMM_W-1:0] imm_in,
    input  logic [2:0]       sel_in,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef ALU_IN2_FWD_EN
    input  logic             fwd_valid,
    input  logic [WIDTH-1:0] fwd_data,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic             err_illegal_sel
);

    state_t           state;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] operand;
    logic             illegal;
    logic             accept;

    alu_in2_format #(
        .WIDTH     (WIDTH),
        .IMM_W     (IMM_W),
        .CONST_INC (CONST_INC),
        .SHAMT     (SHAMT)
    ) u_format (
        .sel       (sel_in),
        .b_in      (b_in),
        .imm_in    (imm_in),
`ifdef ALU_IN2_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data),
`endif
        .operand   (operand),
        .illegal   (illegal)
    );

    // Ready comes straight from registered state so it never depends on out_ready.
    assign in_ready = (state != SKID);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        out_data  <= operand;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (in_valid && out_ready) begin
                        out_data <= operand;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (in_valid) begin
                        // Output is stalled: park the new operand, keep out_data stable.
                        skid_q <= operand;
                        state  <= SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        out_data <= skid_q;
                        state    <= FULL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Set has priority over clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_sel <= 1'b0;
        end else if (accept && illegal) begin
            err_illegal_sel <= 1'b1;
        end else if (err_clr) begin
            err_illegal_sel <= 1'b0;
        end
    end

endmodule
